// File: rtl/traceback_cigar_encoder.sv
// rtl/traceback_cigar_encoder.sv - run-length encodes a traceback path into CIGAR records
// Steps are decoded from successive coordinates, merged into runs and queued in a small record FIFO.
module traceback_cigar_encoder #(
  parameter int          CORD_LENGTH = 8,
  parameter int          LWIDTH      = 8,
  parameter int          FIFO_DEPTH  = 4,
  parameter logic [1:0]  TOP_DIR     = 2'b00,
  parameter logic [1:0]  LEFT_DIR    = 2'b01,
  parameter logic [1:0]  CORNER_DIR  = 2'b10
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [CORD_LENGTH-1:0] in_x,
  input  logic [CORD_LENGTH-1:0] in_y,
  input  logic                   in_last,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [1:0]             out_op,
  output logic [LWIDTH-1:0]      out_len,
  output logic                   out_last,
  output logic                   err,
  output logic                   done
);
  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam int RW = 2 + LWIDTH + 1;
  localparam logic [LWIDTH-1:0]      LEN_MAX = '1;
  localparam logic [CW-1:0]          DEPTH_C = CW'(FIFO_DEPTH);
  localparam logic [CORD_LENGTH-1:0] C_ONE   = CORD_LENGTH'(1);
  localparam logic [CORD_LENGTH-1:0] C_ZERO  = '0;

  typedef enum logic [1:0] {IDLE, RUN, FLUSH, ERR} state_t;

  typedef struct packed {
    logic              open;
    logic [1:0]        op;
    logic [LWIDTH-1:0] len;
    logic              push;
    logic [RW-1:0]     rec;
  } step_t;

  state_t                 state_q, state_d;
  logic [CORD_LENGTH-1:0] prev_x_q, prev_x_d, prev_y_q, prev_y_d;
  logic                   run_open_q, run_open_d;
  logic [1:0]             run_op_q, run_op_d;
  logic [LWIDTH-1:0]      run_len_q, run_len_d;
  logic [RW-1:0]          mem_q [FIFO_DEPTH];
  logic [RW-1:0]          mem_d [FIFO_DEPTH];
  logic [AW-1:0]          rd_q, rd_d, wr_q, wr_d, wp;
  logic [CW-1:0]          count_q, count_d, npush;
  logic                   err_q, err_d;

  logic [CORD_LENGTH-1:0] dx, dy;
  logic [1:0]             step_op;
  logic                   step_ok, accept, pop, push_a, push_b;
  logic [RW-1:0]          rec_a, rec_b, head;
  step_t                  s1, s2;

  // A saturated run is never extended; the next step always closes it.
  function automatic step_t apply_step(input logic open, input logic [1:0] op,
                                       input logic [LWIDTH-1:0] len, input logic [1:0] sop);
    step_t r;
    r.rec = {op, len, 1'b0};
    if (open && op == sop && len != LEN_MAX) begin
      r.open = 1'b1; r.op = op; r.len = len + 1'b1; r.push = 1'b0;
    end else begin
      r.open = 1'b1; r.op = sop; r.len = LWIDTH'(1); r.push = open;
    end
    return r;
  endfunction

  assign head      = mem_q[rd_q];
  assign out_valid = (count_q != '0) && (state_q != ERR);
  assign out_op    = out_valid ? head[RW-1:RW-2] : 2'b00;
  assign out_len   = out_valid ? head[LWIDTH:1] : '0;
  assign out_last  = out_valid & head[0];
  assign pop       = out_valid & out_ready;
  assign done      = pop & out_last;
  assign err       = err_q;
  // Two free slots cover the worst case of a closing run plus the terminal run.
  assign in_ready  = reset && ((state_q == ERR) ||
                     ((state_q == IDLE || state_q == RUN) && (DEPTH_C - count_q) >= CW'(2)));
  assign accept    = in_valid & in_ready;

  always_comb begin
    state_d = state_q; prev_x_d = prev_x_q; prev_y_d = prev_y_q;
    run_open_d = run_open_q; run_op_d = run_op_q; run_len_d = run_len_q;
    mem_d = mem_q; err_d = err_q;
    s1 = '0; s2 = '0;
    push_a = 1'b0; rec_a = '0; push_b = 1'b0; rec_b = '0;
    dx = prev_x_q - in_x;
    dy = prev_y_q - in_y;
    step_ok = 1'b1;
    step_op = CORNER_DIR;
    if (dx == C_ONE && dy == C_ONE)       step_op = CORNER_DIR;
    else if (dx == C_ZERO && dy == C_ONE) step_op = TOP_DIR;
    else if (dx == C_ONE && dy == C_ZERO) step_op = LEFT_DIR;
    else                                  step_ok = 1'b0;

    case (state_q)
      IDLE: if (accept) begin
        prev_x_d = in_x; prev_y_d = in_y;
        run_open_d = in_last; run_op_d = CORNER_DIR; run_len_d = LWIDTH'(1);
        state_d = in_last ? FLUSH : RUN;
      end
      RUN: if (accept) begin
        if (!step_ok) begin
          state_d = ERR;
          err_d   = 1'b1;
        end else begin
          prev_x_d = in_x; prev_y_d = in_y;
          s1 = apply_step(run_open_q, run_op_q, run_len_q, step_op);
          push_a = s1.push; rec_a = s1.rec;
          run_open_d = s1.open; run_op_d = s1.op; run_len_d = s1.len;
          if (in_last) begin
            s2 = apply_step(s1.open, s1.op, s1.len, CORNER_DIR);
            push_b = s2.push; rec_b = s2.rec;
            run_open_d = s2.open; run_op_d = s2.op; run_len_d = s2.len;
            state_d = FLUSH;
          end
        end
      end
      FLUSH: if (count_q != DEPTH_C || pop) begin
        push_a = 1'b1; rec_a = {run_op_q, run_len_q, 1'b1};
        run_open_d = 1'b0;
        state_d = IDLE;
      end
      default: ;
    endcase

    wp = wr_q;
    if (push_a) begin mem_d[wp] = rec_a; wp = wp + 1'b1; end
    if (push_b) begin mem_d[wp] = rec_b; wp = wp + 1'b1; end
    npush   = CW'(push_a) + CW'(push_b);
    wr_d    = wp;
    rd_d    = rd_q + AW'(pop);
    count_d = count_q + npush - CW'(pop);
    if (state_d == ERR) begin
      wr_d = '0; rd_d = '0; count_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE; prev_x_q <= '0; prev_y_q <= '0;
      run_open_q <= 1'b0; run_op_q <= 2'b00; run_len_q <= '0;
      rd_q <= '0; wr_q <= '0; count_q <= '0; err_q <= 1'b0;
    end else begin
      state_q <= state_d; prev_x_q <= prev_x_d; prev_y_q <= prev_y_d;
      run_open_q <= run_open_d; run_op_q <= run_op_d; run_len_q <= run_len_d;
      rd_q <= rd_d; wr_q <= wr_d; count_q <= count_d; err_q <= err_d;
    end
  end

  // Record storage is not reset; the outputs are gated by out_valid instead.
  always_ff @(posedge clk) mem_q <= mem_d;

endmodule

// File: tb/tb_traceback_cigar_encoder.sv
// tb/tb_traceback_cigar_encoder.sv - randomized and directed checks against a path-level CIGAR model
module tb_traceback_cigar_encoder;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic       in_valid, in_ready, in_last, out_valid, out_ready, out_last, err, done;
  logic [7:0] in_x, in_y, out_len;
  logic [1:0] out_op;

  logic       in_valid2, in_ready2, in_last2, out_valid2, out_last2, err2, done2;
  logic       out_ready2;
  logic [7:0] in_x2, in_y2;
  logic [1:0] out_op2, out_len2;

  traceback_cigar_encoder u_dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_x(in_x), .in_y(in_y), .in_last(in_last), .out_valid(out_valid),
    .out_ready(out_ready), .out_op(out_op), .out_len(out_len),
    .out_last(out_last), .err(err), .done(done));

  traceback_cigar_encoder #(.LWIDTH(2)) u_dut2 (
    .clk(clk), .reset(reset), .in_valid(in_valid2), .in_ready(in_ready2),
    .in_x(in_x2), .in_y(in_y2), .in_last(in_last2), .out_valid(out_valid2),
    .out_ready(out_ready2), .out_op(out_op2), .out_len(out_len2),
    .out_last(out_last2), .err(err2), .done(done2));

  typedef struct {int op; int len; bit last;} rec_t;

  int   errors = 0;
  int   checks = 0;
  rec_t exp_q[$];
  rec_t model_q[$];
  rec_t got2_q[$];
  int   path_x[$];
  int   path_y[$];
  rec_t head_e;
  bit   hold0   = 1'b1;
  bit   rnd_rdy = 1'b0;
  bit   gaps    = 1'b0;
  int   done2_n = 0;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  // Reference: list the op of every step plus the terminal corner, then run-length encode it.
  function automatic void build_model(input int lmax);
    int ops[$];
    int cur, len, dx, dy;
    rec_t r;
    model_q.delete();
    for (int i = 1; i < path_x.size(); i++) begin
      dx = path_x[i-1] - path_x[i];
      dy = path_y[i-1] - path_y[i];
      if (dx == 1 && dy == 1)      ops.push_back(2);
      else if (dx == 0 && dy == 1) ops.push_back(0);
      else if (dx == 1 && dy == 0) ops.push_back(1);
      else                         ops.push_back(-1);
    end
    ops.push_back(2);
    cur = -1; len = 0;
    foreach (ops[i]) begin
      if (ops[i] == cur && len < lmax) len++;
      else begin
        if (cur >= 0) begin r.op = cur; r.len = len; r.last = 1'b0; model_q.push_back(r); end
        cur = ops[i]; len = 1;
      end
    end
    r.op = cur; r.len = len; r.last = 1'b1;
    model_q.push_back(r);
  endfunction

  task automatic set_path(input int xs[$], input int ys[$]);
    path_x = xs; path_y = ys;
  endtask

  task automatic diag_path(input int n);
    path_x.delete(); path_y.delete();
    for (int i = n; i >= 0; i--) begin path_x.push_back(i); path_y.push_back(i); end
  endtask

  task automatic pin(input string name, input int idx, input int op, input int len, input int last);
    if (idx >= model_q.size()) check({name, " size"}, model_q.size(), idx + 1);
    else begin
      check({name, " op"}, model_q[idx].op, op);
      check({name, " len"}, model_q[idx].len, len);
      check({name, " last"}, int'(model_q[idx].last), last);
    end
  endtask

  // Called at posedge+1; returns at posedge+1 after the coordinate is taken.
  task automatic send(input int x, input int y, input bit last);
    int n;
    in_valid = 1'b1; in_x = 8'(x); in_y = 8'(y); in_last = last;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 300) begin n++; @(negedge clk); end
    if (n >= 300) check("in_ready timeout", 0, 1);
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic send_range(input int from, input int to, input bit with_last);
    for (int i = from; i < to; i++) begin
      send(path_x[i], path_y[i], with_last && (i == path_x.size() - 1));
      if (gaps) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    end
  endtask

  task automatic run_path();
    build_model(255);
    foreach (model_q[i]) exp_q.push_back(model_q[i]);
    send_range(0, path_x.size(), 1'b1);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() > 0 && n < 3000) begin @(negedge clk); n++; end
    check("drain remaining records", exp_q.size(), 0);
    @(posedge clk); #1;
  endtask

  task automatic pulse_reset();
    @(posedge clk); #1; reset = 1'b0;
    repeat (2) @(posedge clk);
    #1; reset = 1'b1;
  endtask

  task automatic random_path();
    int x, y, r;
    path_x.delete(); path_y.delete();
    x = $urandom_range(0, 12); y = $urandom_range(0, 12);
    path_x.push_back(x); path_y.push_back(y);
    while (x > 0 || y > 0) begin
      r = $urandom_range(0, 2);
      if (r == 0 && x > 0 && y > 0) begin x--; y--; end
      else if (r == 1 && y > 0) y--;
      else if (x > 0) x--;
      else y--;
      path_x.push_back(x); path_y.push_back(y);
    end
  endtask

  always @(posedge clk) begin
    #1;
    out_ready = hold0 ? 1'b0 : (rnd_rdy ? ($urandom_range(0, 3) != 0) : 1'b1);
  end

  always @(negedge clk) begin
    if (reset) begin
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) check("unexpected record", 1, 0);
        else begin
          head_e = exp_q.pop_front();
          check("out_op", int'(out_op), head_e.op);
          check("out_len", int'(out_len), head_e.len);
          check("out_last", int'(out_last), int'(head_e.last));
          check("done on transfer", int'(done), int'(head_e.last));
        end
      end else check("done without transfer", int'(done), 0);
      if (out_valid2 && out_ready2) begin
        head_e.op = int'(out_op2); head_e.len = int'(out_len2); head_e.last = out_last2;
        got2_q.push_back(head_e);
      end
      if (done2) done2_n++;
    end
  end

  initial begin
    reset = 1'b0; in_valid = 1'b0; in_x = '0; in_y = '0; in_last = 1'b0;
    in_valid2 = 1'b0; in_x2 = '0; in_y2 = '0; in_last2 = 1'b0; out_ready2 = 1'b1;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset out_valid", int'(out_valid), 0);
    check("reset out_op", int'(out_op), 0);
    check("reset out_len", int'(out_len), 0);
    check("reset out_last", int'(out_last), 0);
    check("reset err", int'(err), 0);
    check("reset done", int'(done), 0);
    check("reset in_ready", int'(in_ready), 0);
    @(posedge clk); #1; reset = 1'b1;
    @(negedge clk);
    check("in_ready after release", int'(in_ready), 1);
    @(posedge clk); #1;
    hold0 = 1'b0;

    set_path('{2, 1, 0}, '{2, 1, 0});
    build_model(255);
    check("pin diag3 size", model_q.size(), 1);
    pin("pin diag3", 0, 2, 3, 1);
    run_path();
    drain();

    set_path('{2, 2, 1, 0}, '{2, 1, 1, 0});
    build_model(255);
    check("pin IDM size", model_q.size(), 3);
    pin("pin IDM r0", 0, 0, 1, 0);
    pin("pin IDM r1", 1, 1, 1, 0);
    pin("pin IDM r2", 2, 2, 2, 1);
    run_path();
    drain();

    set_path('{0}, '{0});
    build_model(255);
    pin("pin single", 0, 2, 1, 1);
    run_path();
    drain();

    path_x.delete(); path_y.delete();
    for (int i = 6; i > 0; i--) begin
      path_x.push_back(i); path_y.push_back(i);
      path_x.push_back(i); path_y.push_back(i - 1);
    end
    path_x.push_back(0); path_y.push_back(0);
    build_model(255);
    check("alt model size", model_q.size(), 13);
    foreach (model_q[i]) exp_q.push_back(model_q[i]);
    hold0 = 1'b1;
    @(posedge clk); #1;
    send_range(0, 5, 1'b1);
    repeat (3) begin
      @(negedge clk);
      check("backpressure in_ready", int'(in_ready), 0);
      check("backpressure out_valid", int'(out_valid), 1);
    end
    @(posedge clk); #1;
    hold0 = 1'b0; rnd_rdy = 1'b1;
    send_range(5, path_x.size(), 1'b1);
    drain();

    send(3, 3, 1'b0);
    send(1, 1, 1'b0);
    @(negedge clk);
    check("illegal step err", int'(err), 1);
    check("illegal step out_valid", int'(out_valid), 0);
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("err in_ready", int'(in_ready), 1);
      @(posedge clk); #1;
      send(i + 5, 0, i == 2);
    end
    @(negedge clk);
    check("err sticky", int'(err), 1);
    check("err out_valid", int'(out_valid), 0);
    @(posedge clk); #1;
    pulse_reset();
    @(negedge clk);
    check("err cleared by reset", int'(err), 0);
    @(posedge clk); #1;

    send(4, 4, 1'b0);
    send(3, 3, 1'b0);
    pulse_reset();
    set_path('{1, 0}, '{1, 0});
    build_model(255);
    pin("pin after reset", 0, 2, 2, 1);
    run_path();
    drain();

    gaps = 1'b1;
    repeat (40) begin
      random_path();
      run_path();
    end
    drain();
    gaps = 1'b0;

    diag_path(5);
    build_model(3);
    check("pin sat size", model_q.size(), 2);
    pin("pin sat r0", 0, 2, 3, 0);
    pin("pin sat r1", 1, 2, 3, 1);
    for (int i = 5; i >= 0; i--) begin
      int n;
      in_valid2 = 1'b1; in_x2 = 8'(i); in_y2 = 8'(i); in_last2 = (i == 0);
      n = 0;
      @(negedge clk);
      while (!in_ready2 && n < 100) begin n++; @(negedge clk); end
      if (n >= 100) check("lw2 in_ready timeout", 0, 1);
      @(posedge clk); #1;
    end
    in_valid2 = 1'b0; in_last2 = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    check("lw2 record count", got2_q.size(), model_q.size());
    for (int i = 0; i < got2_q.size() && i < model_q.size(); i++) begin
      check("lw2 op", got2_q[i].op, model_q[i].op);
      check("lw2 len", got2_q[i].len, model_q[i].len);
      check("lw2 last", int'(got2_q[i].last), int'(model_q[i].last));
    end
    check("lw2 done pulses", done2_n, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
